// File: rtl/morra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morra_pkg
// Description : Shared encodings, state enum and record field widths for the
//               Morra scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package morra_pkg;

    // Round and game results share one 2-bit encoding; TIE and DRAW are the same code.
    localparam logic [1:0] c_RES_NONE = 2'b00;
    localparam logic [1:0] c_RES_P1   = 2'b01;
    localparam logic [1:0] c_RES_P2   = 2'b10;
    localparam logic [1:0] c_RES_TIE  = 2'b11;
    localparam logic [1:0] c_RES_DRAW = 2'b11;

    localparam int RND_CNT_W  = 4;
    localparam int GAME_CNT_W = 3;
    localparam int IDX_W      = 3;
    localparam int RES_W      = 2;
    localparam int REC_W      = IDX_W + RES_W + 2 * RND_CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [RND_CNT_W-1:0] sat_inc(input logic [RND_CNT_W-1:0] v,
                                                     input logic               en);
        if (en && (v != '1))
            return v + RND_CNT_W'(1);
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morra_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : morra_result_fifo
// Description : Small valid/ready record buffer with a sticky drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
module morra_result_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow
);

    localparam int               c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_FULL  = DEPTH[c_PTR_W:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;

    logic w_full;
    logic w_pop;
    logic w_wr_en;

    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == c_FULL);
    assign w_pop     = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
    assign w_wr_en   = push && (!w_full || w_pop);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (push && !w_wr_en)
                r_overflow <= 1'b1;
        end
    end

    // Storage is not reset; the read port is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/morra_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : morra_scoreboard
// Description : Round/game/match tally for Morra with a game-record stream.
// Revision    : 1.0 - initial release
// ============================================================================
module morra_scoreboard
    import morra_pkg::*;
#(
    parameter int MATCH_WINS = 2,
    parameter int MAX_GAMES  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  START,
    input  logic [1:0]            ROUND,
    input  logic [1:0]            GAME,
    output logic [RND_CNT_W-1:0]  R1_WINS,
    output logic [RND_CNT_W-1:0]  R2_WINS,
    output logic [RND_CNT_W-1:0]  R_TIES,
    output logic [GAME_CNT_W-1:0] G1_WINS,
    output logic [GAME_CNT_W-1:0] G2_WINS,
    output logic [1:0]            MATCH,
    output logic                  MATCH_VALID,
    output logic                  EV_VALID,
    input  logic                  EV_READY,
    output logic [REC_W-1:0]      EV_DATA,
    output logic                  OVF
);

    localparam logic [GAME_CNT_W-1:0] c_WIN_CNT = GAME_CNT_W'(MATCH_WINS);
    localparam logic [IDX_W-1:0]      c_MAX_IDX = IDX_W'(MAX_GAMES);

    state_t                r_state;
    logic [RND_CNT_W-1:0]  r_r1;
    logic [RND_CNT_W-1:0]  r_r2;
    logic [RND_CNT_W-1:0]  r_ties;
    logic [GAME_CNT_W-1:0] r_g1;
    logic [GAME_CNT_W-1:0] r_g2;
    logic [IDX_W-1:0]      r_idx;
    logic [1:0]            r_match;
    logic                  r_match_valid;

    logic                  w_active;
    logic                  w_game_done;
    logic [RND_CNT_W-1:0]  w_r1_next;
    logic [RND_CNT_W-1:0]  w_r2_next;
    logic [RND_CNT_W-1:0]  w_ties_next;
    logic [GAME_CNT_W-1:0] w_g1_next;
    logic [GAME_CNT_W-1:0] w_g2_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic [1:0]            w_match;
    logic [REC_W-1:0]      w_rec;

    // START wins over ROUND/GAME in the same cycle.
    assign w_active    = (r_state == ST_PLAY) && !START;
    assign w_game_done = w_active && (GAME != c_RES_NONE);

    assign w_r1_next   = sat_inc(r_r1,   w_active && (ROUND == c_RES_P1));
    assign w_r2_next   = sat_inc(r_r2,   w_active && (ROUND == c_RES_P2));
    assign w_ties_next = sat_inc(r_ties, w_active && (ROUND == c_RES_TIE));
    assign w_g1_next   = r_g1 + GAME_CNT_W'(GAME == c_RES_P1);
    assign w_g2_next   = r_g2 + GAME_CNT_W'(GAME == c_RES_P2);
    assign w_idx_next  = r_idx + IDX_W'(1);
    assign w_rec       = {w_idx_next, GAME, w_r1_next, w_r2_next};

    always_comb begin
        w_match = c_RES_NONE;
        if (w_g1_next == c_WIN_CNT)
            w_match = c_RES_P1;
        else if (w_g2_next == c_WIN_CNT)
            w_match = c_RES_P2;
        else if (w_idx_next == c_MAX_IDX) begin
            if (w_g1_next > w_g2_next)
                w_match = c_RES_P1;
            else if (w_g2_next > w_g1_next)
                w_match = c_RES_P2;
            else
                w_match = c_RES_DRAW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_r1          <= '0;
            r_r2          <= '0;
            r_ties        <= '0;
            r_g1          <= '0;
            r_g2          <= '0;
            r_idx         <= '0;
            r_match       <= c_RES_NONE;
            r_match_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        r_state       <= ST_PLAY;
                        r_r1          <= '0;
                        r_r2          <= '0;
                        r_ties        <= '0;
                        r_g1          <= '0;
                        r_g2          <= '0;
                        r_idx         <= '0;
                        r_match       <= c_RES_NONE;
                        r_match_valid <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (START) begin
                        r_r1   <= '0;
                        r_r2   <= '0;
                        r_ties <= '0;
                    end else if (w_game_done) begin
                        r_r1   <= '0;
                        r_r2   <= '0;
                        r_ties <= '0;
                        r_g1   <= w_g1_next;
                        r_g2   <= w_g2_next;
                        r_idx  <= w_idx_next;
                        if (w_match != c_RES_NONE) begin
                            r_state       <= ST_DONE;
                            r_match       <= w_match;
                            r_match_valid <= 1'b1;
                        end
                    end else begin
                        r_r1   <= w_r1_next;
                        r_r2   <= w_r2_next;
                        r_ties <= w_ties_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    morra_result_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_game_done),
        .push_data (w_rec),
        .out_valid (EV_VALID),
        .out_ready (EV_READY),
        .out_data  (EV_DATA),
        .overflow  (OVF)
    );

    assign R1_WINS     = r_r1;
    assign R2_WINS     = r_r2;
    assign R_TIES      = r_ties;
    assign G1_WINS     = r_g1;
    assign G2_WINS     = r_g2;
    assign MATCH       = r_match;
    assign MATCH_VALID = r_match_valid;

endmodule
`default_nettype wire

// File: tb/tb_morra_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_morra_scoreboard
// Description : Directed self-checking bench; two instances (MATCH_WINS 2 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morra_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       START;
    logic [1:0] ROUND;
    logic [1:0] GAME;
    logic       EV_READY;

    logic [3:0]  d2_r1, d2_r2, d2_rt, d3_r1, d3_r2, d3_rt;
    logic [2:0]  d2_g1, d2_g2, d3_g1, d3_g2;
    logic [1:0]  d2_match, d3_match;
    logic        d2_mv, d3_mv, d2_ev_valid, d3_ev_valid, d2_ovf, d3_ovf;
    logic [12:0] d2_ev_data, d3_ev_data;

    morra_scoreboard u_dut2 (
        .clk(clk), .rst_n(rst_n), .START(START), .ROUND(ROUND), .GAME(GAME),
        .R1_WINS(d2_r1), .R2_WINS(d2_r2), .R_TIES(d2_rt),
        .G1_WINS(d2_g1), .G2_WINS(d2_g2), .MATCH(d2_match), .MATCH_VALID(d2_mv),
        .EV_VALID(d2_ev_valid), .EV_READY(EV_READY), .EV_DATA(d2_ev_data), .OVF(d2_ovf)
    );

    morra_scoreboard #(.MATCH_WINS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .START(START), .ROUND(ROUND), .GAME(GAME),
        .R1_WINS(d3_r1), .R2_WINS(d3_r2), .R_TIES(d3_rt),
        .G1_WINS(d3_g1), .G2_WINS(d3_g2), .MATCH(d3_match), .MATCH_VALID(d3_mv),
        .EV_VALID(d3_ev_valid), .EV_READY(EV_READY), .EV_DATA(d3_ev_data), .OVF(d3_ovf)
    );

    // Accepted records, captured mid-cycle ahead of the transferring edge.
    logic [12:0] q2[$];
    logic [12:0] q3[$];
    always @(negedge clk) begin
        if (rst_n && d2_ev_valid && EV_READY) q2.push_back(d2_ev_data);
        if (rst_n && d3_ev_valid && EV_READY) q3.push_back(d3_ev_data);
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] rec(input logic [2:0] idx, input logic [1:0] res,
                                        input logic [3:0] a, input logic [3:0] b);
        return {idx, res, a, b};
    endfunction

    function automatic logic [12:0] q2_at(input int i);
        return (i < q2.size()) ? q2[i] : 13'h1fff;
    endfunction

    function automatic logic [12:0] q3_at(input int i);
        return (i < q3.size()) ? q3[i] : 13'h1fff;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        START = 1'b0; ROUND = 2'b00; GAME = 2'b00; EV_READY = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic start_game();
        START = 1'b1; tick(); START = 1'b0;
    endtask

    task automatic play(input logic [1:0] r);
        ROUND = r; tick(); ROUND = 2'b00;
    endtask

    task automatic finish_game(input logic [1:0] r, input logic [1:0] g);
        ROUND = r; GAME = g; tick(); ROUND = 2'b00; GAME = 2'b00;
    endtask

    task automatic game(input logic [1:0] r, input logic [1:0] g);
        start_game();
        finish_game(r, g);
    endtask

    int b2, b3;

    initial begin
        START = 1'b0; ROUND = 2'b00; GAME = 2'b00; EV_READY = 1'b0; rst_n = 1'b0;
        tick(2);
        check("rst_d2_outs", 32'({d2_r1, d2_r2, d2_rt, d2_g1, d2_g2, d2_match, d2_mv, d2_ev_valid, d2_ovf}), 32'd0);
        check("rst_d2_data", 32'(d2_ev_data), 32'd0);
        check("rst_d3_outs", 32'({d3_r1, d3_r2, d3_rt, d3_g1, d3_g2, d3_match, d3_mv,
                                  d3_ev_valid, d3_ovf, d3_ev_data}), 32'd0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores ROUND and GAME
        play(2'b01);
        check("idle_round", 32'(d2_r1), 32'd0);
        finish_game(2'b01, 2'b01);
        check("idle_game", 32'({d2_ev_valid, d2_g1}), 32'd0);

        // single P1 game
        start_game();
        play(2'b01); play(2'b10); play(2'b01); play(2'b11); play(2'b01);
        check("g1_r1", 32'(d2_r1), 32'd3);
        check("g1_r2", 32'(d2_r2), 32'd1);
        check("g1_ties", 32'(d2_rt), 32'd1);
        finish_game(2'b01, 2'b01);
        check("g1_ev_valid", 32'(d2_ev_valid), 32'd1);
        check("g1_record", 32'(d2_ev_data), 32'(rec(3'd1, 2'b01, 4'd4, 4'd1)));
        check("g1_rounds_clr", 32'({d2_r1, d2_r2, d2_rt}), 32'd0);
        check("g1_g1wins", 32'(d2_g1), 32'd1);
        check("g1_no_match", 32'(d2_mv), 32'd0);
        play(2'b10);
        check("wait_round_counted", 32'(d2_r2), 32'd1);
        b2 = q2.size();
        EV_READY = 1'b1;
        tick(2);
        check("g1_drain_cnt", 32'(q2.size() - b2), 32'd1);
        check("g1_drain_rec", 32'(q2_at(b2)), 32'(rec(3'd1, 2'b01, 4'd4, 4'd1)));
        check("g1_drain_empty", 32'(d2_ev_valid), 32'd0);

        // second P1 game decides the match
        start_game();
        check("play_restart_r2", 32'(d2_r2), 32'd0);
        check("play_restart_g1", 32'(d2_g1), 32'd1);
        b2 = q2.size();
        finish_game(2'b01, 2'b01);
        check("m_match", 32'(d2_match), 32'(2'b01));
        check("m_valid", 32'(d2_mv), 32'd1);
        check("m_g1", 32'(d2_g1), 32'd2);
        tick(2);
        check("m_rec", 32'(q2_at(b2)), 32'(rec(3'd2, 2'b01, 4'd1, 4'd0)));
        b2 = q2.size();
        play(2'b01);
        finish_game(2'b10, 2'b10);
        tick(2);
        check("done_ignore_cnt", 32'({d2_r1, d2_r2, d2_g2}), 32'd0);
        check("done_hold_match", 32'({d2_mv, d2_match}), 32'({1'b1, 2'b01}));
        check("done_no_rec", 32'(q2.size() - b2), 32'd0);
        start_game();
        check("done_restart", 32'({d2_mv, d2_match, d2_g1}), 32'd0);

        // five games P1,P2,draw,P2,P1
        do_reset();
        EV_READY = 1'b1;
        b3 = q3.size();
        game(2'b01, 2'b01);
        game(2'b10, 2'b10);
        game(2'b00, 2'b11);
        game(2'b10, 2'b10);
        check("five_d2_match", 32'({d2_mv, d2_match}), 32'({1'b1, 2'b10}));
        check("five_d3_open", 32'(d3_mv), 32'd0);
        game(2'b01, 2'b01);
        check("five_d3_match", 32'({d3_mv, d3_match}), 32'({1'b1, 2'b11}));
        tick(2);
        check("five_cnt", 32'(q3.size() - b3), 32'd5);
        check("five_rec1", 32'(q3_at(b3)),     32'(rec(3'd1, 2'b01, 4'd1, 4'd0)));
        check("five_rec2", 32'(q3_at(b3 + 1)), 32'(rec(3'd2, 2'b10, 4'd0, 4'd1)));
        check("five_rec3", 32'(q3_at(b3 + 2)), 32'(rec(3'd3, 2'b11, 4'd0, 4'd0)));
        check("five_rec4", 32'(q3_at(b3 + 3)), 32'(rec(3'd4, 2'b10, 4'd0, 4'd1)));
        check("five_rec5", 32'(q3_at(b3 + 4)), 32'(rec(3'd5, 2'b01, 4'd1, 4'd0)));

        // back-pressure: fifth record dropped
        do_reset();
        game(2'b01, 2'b01);
        game(2'b10, 2'b10);
        game(2'b00, 2'b11);
        game(2'b00, 2'b11);
        check("bp_full_noovf", 32'({d2_ovf, d2_ev_valid, d2_mv}), 32'(3'b010));
        game(2'b00, 2'b11);
        check("bp_ovf", 32'(d2_ovf), 32'd1);
        check("bp_match", 32'({d2_mv, d2_match}), 32'({1'b1, 2'b11}));
        check("bp_head_stable", 32'(d2_ev_data), 32'(rec(3'd1, 2'b01, 4'd1, 4'd0)));
        start_game();
        check("bp_survive_start", 32'({d2_ev_valid, d2_mv}), 32'(2'b10));
        check("bp_survive_head", 32'(d2_ev_data), 32'(rec(3'd1, 2'b01, 4'd1, 4'd0)));
        b2 = q2.size();
        EV_READY = 1'b1;
        tick(6);
        check("bp_cnt", 32'(q2.size() - b2), 32'd4);
        check("bp_rec1", 32'(q2_at(b2)),     32'(rec(3'd1, 2'b01, 4'd1, 4'd0)));
        check("bp_rec2", 32'(q2_at(b2 + 1)), 32'(rec(3'd2, 2'b10, 4'd0, 4'd1)));
        check("bp_rec3", 32'(q2_at(b2 + 2)), 32'(rec(3'd3, 2'b11, 4'd0, 4'd0)));
        check("bp_rec4", 32'(q2_at(b2 + 3)), 32'(rec(3'd4, 2'b11, 4'd0, 4'd0)));
        check("bp_end", 32'({d2_ev_valid, d2_ovf}), 32'(2'b01));

        // push and pop together while full
        do_reset();
        b2 = q2.size();
        game(2'b01, 2'b01);
        game(2'b10, 2'b10);
        game(2'b00, 2'b11);
        game(2'b00, 2'b11);
        start_game();
        ROUND = 2'b00; GAME = 2'b11; EV_READY = 1'b1;
        tick();
        GAME = 2'b00;
        check("full_pp_noovf", 32'(d2_ovf), 32'd0);
        tick(6);
        check("full_pp_cnt", 32'(q2.size() - b2), 32'd5);
        check("full_pp_rec5", 32'(q2_at(b2 + 4)), 32'(rec(3'd5, 2'b11, 4'd0, 4'd0)));

        // saturation and mid-game restart
        do_reset();
        EV_READY = 1'b1;
        game(2'b01, 2'b01);
        tick(2);
        b2 = q2.size();
        start_game();
        repeat (16) play(2'b01);
        check("sat_r1", 32'(d2_r1), 32'd15);
        play(2'b10);
        check("sat_r2", 32'(d2_r2), 32'd1);
        start_game();
        check("mid_clear", 32'({d2_r1, d2_r2, d2_rt}), 32'd0);
        check("mid_g1_kept", 32'(d2_g1), 32'd1);
        tick(2);
        check("mid_no_rec", 32'(q2.size() - b2), 32'd0);
        repeat (16) play(2'b01);
        finish_game(2'b01, 2'b01);
        tick(2);
        check("sat_rec", 32'(q2_at(b2)), 32'(rec(3'd2, 2'b01, 4'd15, 4'd0)));
        check("sat_match", 32'({d2_mv, d2_match}), 32'({1'b1, 2'b01}));

        // asynchronous reset mid-handshake
        do_reset();
        game(2'b01, 2'b01);
        check("ar_pending", 32'(d2_ev_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_outs", 32'({d2_r1, d2_r2, d2_rt, d2_g1, d2_g2, d2_match, d2_mv, d2_ev_valid, d2_ovf}), 32'd0);
        check("ar_data", 32'(d2_ev_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        play(2'b01);
        check("ar_idle_after", 32'({d2_r1, d2_ev_valid}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
